lifo_arbiter: RTL and testbench
===============================

LIFO_ARBITER -- requirements
Module: lifo_arbiter

Interface
REQ-001 Parameter pBITS, default 8, data word width in bits.
REQ-002 iclk  input  1  single clock; all state updates on its rising edge.
REQ-003 ireset  input  1  reset; synchronous and active-high.
REQ-004 ivalid0, ivalid1  input  1 each  requester 0/1 command valid.
REQ-005 iop0, iop1  input  1 each  command type: 0 = push, 1 = pop.
REQ-006 idata0, idata1  input  pBITS each  push data.
REQ-007 oready0, oready1  output  1 each  command accepted this cycle when ivalidN & oreadyN.
REQ-008 orsp_valid0, orsp_valid1  output  1 each  one-cycle pop-response strobe.
REQ-009 orsp_data  output  pBITS  pop data; shared by both requesters, qualified by orsp_validN.
REQ-010 owr  output  1  stack write strobe to the shared LIFO.
REQ-011 ord  output  1  stack read/pop strobe to the shared LIFO.
REQ-012 ow_data  output  pBITS  stack write data.
REQ-013 ir_data  input  pBITS  stack top-of-stack read data, combinational from stack.
REQ-014 iempty, ifull  input  1 each  stack status flags.

Function
REQ-015 The FSM shall have two states: IDLE and ISSUE.
REQ-016 In IDLE, a command is legal when it is a push with ifull=0 or a pop with iempty=0.
REQ-017 In IDLE, oreadyN shall be 1 only for the requester granted this cycle; at most one oready high per cycle.
REQ-018 Grant: if exactly one requester has a valid legal command, it is granted; if both do, the requester not granted most recently wins (round-robin).
REQ-019 Illegal commands shall not be granted and shall not block a legal command from the other requester.
REQ-020 On accept, the block shall register op, data and requester ID, update the round-robin pointer to the accepted ID, and go to ISSUE.
REQ-021 In ISSUE, owr=1 for a push (ow_data = registered data) or ord=1 for a pop, for exactly one cycle; all oready=0.
REQ-022 In ISSUE for a pop, ir_data shall be captured into orsp_data at the same edge that ends ISSUE.
REQ-023 ISSUE shall always return to IDLE after one cycle; throughput is one command per 2 cycles.
REQ-024 Pop response: orsp_validN shall pulse for 1 cycle, 2 cycles after the accept cycle, for the requester that issued the pop; orsp_data holds until the next pop capture.
REQ-025 owr, ord, orsp_valid0/1 shall be registered outputs; owr and ord shall never both be 1.
REQ-026 A push is never issued while ifull=1 and a pop is never issued while iempty=1 at the accept cycle.
REQ-027 Requester inputs are sampled only in the accept cycle; changes while oready=0 have no effect.

Reset
REQ-028 While ireset=1 at a rising edge: state=IDLE, owr=0, ord=0, orsp_valid0/1=0, orsp_data=0, ow_data=0, round-robin pointer favours requester 0.
REQ-029 Reset during ISSUE shall abort the command: no owr/ord pulse and no orsp_valid in the cycle after reset.
REQ-030 oready0/1 shall be 0 in any cycle in which ireset=1.
REQ-031 ireset shall be driven to the shared LIFO as well, so stack and controller reset together.

Verification
REQ-032 Reset, then requester 0 pushes 0xA5 to empty stack -> oready0=1 in cycle 0, owr=1 with ow_data=0xA5 in cycle 1, no orsp_valid.
REQ-033 Stack holds 0x3C on top; requester 1 pops -> ord=1 in cycle 1, orsp_valid1=1 with orsp_data=0x3C in cycle 2, orsp_valid0 stays 0.
REQ-034 Both requesters hold valid legal pushes (0x11, 0x22) continuously after reset -> grants alternate 0,1,0,1 on cycles 0,2,4,6; stack receives 0x11,0x22,0x11,0x22.
REQ-035 Stack empty; requester 0 pops, requester 1 pushes 0x77 -> requester 1 granted, oready0 stays 0 until iempty=0, then requester 0's pop returns 0x77.
REQ-036 Stack full (4 entries, pBITS=8); requester 0 pushes -> oready0 stays 0, owr never asserts until a pop clears ifull.
REQ-037 ireset asserted in ISSUE of a pop -> ord=0 and orsp_valid0/1=0 in the next cycle, state IDLE, next simultaneous request granted to requester 0.

Source files
------------

// File: rtl/lifo_arbiter.sv
// lifo_arbiter: round-robin arbiter sharing one LIFO stack between two requesters
module lifo_arbiter #(
  parameter int pBITS = 8
) (
  input  logic             iclk,
  input  logic             ireset,
  input  logic             ivalid0,
  input  logic             ivalid1,
  input  logic             iop0,
  input  logic             iop1,
  input  logic [pBITS-1:0] idata0,
  input  logic [pBITS-1:0] idata1,
  output logic             oready0,
  output logic             oready1,
  output logic             orsp_valid0,
  output logic             orsp_valid1,
  output logic [pBITS-1:0] orsp_data,
  output logic             owr,
  output logic             ord,
  output logic [pBITS-1:0] ow_data,
  input  logic [pBITS-1:0] ir_data,
  input  logic             iempty,
  input  logic             ifull
);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_nxt;
  logic legal0, legal1, gnt0, gnt1, acc, sel_op, last, op_r, id_r;
  logic [pBITS-1:0] sel_data;
  // state register
  always_ff @(posedge iclk) state <= ireset ? IDLE : state_nxt;
  // legality, round-robin grant and next state; last=1 means requester 1 won most recently
  always_comb begin
    legal0    = ivalid0 & (iop0 ? ~iempty : ~ifull);
    legal1    = ivalid1 & (iop1 ? ~iempty : ~ifull);
    gnt1      = legal1 & (~legal0 | ~last);
    gnt0      = legal0 & ~gnt1;
    acc       = (state == IDLE) & ~ireset & (legal0 | legal1);
    oready0   = acc & gnt0;
    oready1   = acc & gnt1;
    sel_op    = gnt1 ? iop1 : iop0;
    sel_data  = gnt1 ? idata1 : idata0;
    state_nxt = acc ? ISSUE : IDLE;
  end
  // command capture, registered stack strobes and pop response
  always_ff @(posedge iclk) begin
    if (ireset) begin
      owr         <= 1'b0;
      ord         <= 1'b0;
      orsp_valid0 <= 1'b0;
      orsp_valid1 <= 1'b0;
      orsp_data   <= '0;
      ow_data     <= '0;
      last        <= 1'b1;
      op_r        <= 1'b0;
      id_r        <= 1'b0;
    end else begin
      owr         <= acc & ~sel_op;
      ord         <= acc & sel_op;
      orsp_valid0 <= (state == ISSUE) & op_r & ~id_r;
      orsp_valid1 <= (state == ISSUE) & op_r & id_r;
      if (acc) begin
        op_r    <= sel_op;
        id_r    <= gnt1;
        last    <= gnt1;
        ow_data <= sel_data;
      end
      if ((state == ISSUE) & op_r) orsp_data <= ir_data;
    end
  end
endmodule

// File: tb/tb_lifo_arbiter.sv
// tb_lifo_arbiter: randomized scoreboard bench with a behavioural stack and arbitration model
module tb_lifo_arbiter;
  logic       iclk = 0, ireset = 1;
  logic       ivalid0 = 0, ivalid1 = 0, iop0 = 0, iop1 = 0;
  logic [7:0] idata0 = 0, idata1 = 0;
  logic       oready0, oready1, orsp_valid0, orsp_valid1, owr, ord, iempty, ifull;
  logic [7:0] orsp_data, ow_data, ir_data;
  logic [7:0] mem [4];
  int         cnt = 0, cyc = 0, ncmp = 0, nbad = 0;
  bit         started = 0, rst_prev = 0, busy = 0, prefer = 0;
  typedef struct {int c; bit id; logic [7:0] d;} ev_t;
  ev_t        wq[$], rq[$], pq[$];
  logic [7:0] ms[$];

  lifo_arbiter #(.pBITS(8)) dut (
    .iclk(iclk), .ireset(ireset), .ivalid0(ivalid0), .ivalid1(ivalid1),
    .iop0(iop0), .iop1(iop1), .idata0(idata0), .idata1(idata1),
    .oready0(oready0), .oready1(oready1), .orsp_valid0(orsp_valid0),
    .orsp_valid1(orsp_valid1), .orsp_data(orsp_data), .owr(owr), .ord(ord),
    .ow_data(ow_data), .ir_data(ir_data), .iempty(iempty), .ifull(ifull));

  always #5 iclk = ~iclk;

  // shared 4-deep LIFO seen by the controller, reset together with it
  assign iempty  = (cnt == 0);
  assign ifull   = (cnt == 4);
  assign ir_data = (cnt > 0) ? mem[cnt-1] : 8'h00;
  always @(posedge iclk) begin
    cyc     <= cyc + 1;
    started <= started | ireset;
    if (ireset) cnt <= 0;
    else if (owr && cnt < 4) begin
      mem[cnt] <= ow_data;
      cnt      <= cnt + 1;
    end else if (ord && cnt > 0) cnt <= cnt - 1;
  end

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    ncmp++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s cycle %0d: got %h expected %h", n, cyc, a, e);
    end
  endtask

  // monitor: pop expected events when due, predict grants from the model, then advance the model
  always @(negedge iclk) begin
    bit ew, er, ep, l0, l1, op;
    int g;
    ev_t e;
    if (started) begin
      ew = wq.size() > 0 && wq[0].c == cyc;
      er = rq.size() > 0 && rq[0].c == cyc;
      ep = pq.size() > 0 && pq[0].c == cyc;
      chk("owr", 8'(owr), 8'(ew));
      if (ew) begin
        e = wq.pop_front();
        chk("ow_data", ow_data, e.d);
      end
      chk("ord", 8'(ord), 8'(er));
      if (er) void'(rq.pop_front());
      e = ep ? pq.pop_front() : '{0, 1'b0, 8'h00};
      chk("orsp_valid0", 8'(orsp_valid0), 8'(ep && !e.id));
      chk("orsp_valid1", 8'(orsp_valid1), 8'(ep && e.id));
      if (ep) chk("orsp_data", orsp_data, e.d);
      if (rst_prev) begin
        chk("reset orsp_data", orsp_data, 8'h00);
        chk("reset ow_data", ow_data, 8'h00);
      end
      l0 = ivalid0 && (iop0 ? ms.size() > 0 : ms.size() < 4);
      l1 = ivalid1 && (iop1 ? ms.size() > 0 : ms.size() < 4);
      g  = (ireset || busy || !(l0 || l1)) ? -1 : (l0 && l1) ? int'(prefer) : l1 ? 1 : 0;
      chk("oready0", 8'(oready0), 8'(g == 0));
      chk("oready1", 8'(oready1), 8'(g == 1));
      rst_prev = ireset;
      if (ireset) begin
        wq.delete(); rq.delete(); pq.delete(); ms.delete();
        busy = 0; prefer = 0;
      end else if (busy) busy = 0;
      else if (g >= 0) begin
        busy   = 1;
        prefer = (g == 0);
        op     = g ? iop1 : iop0;
        if (!op) begin
          ms.push_back(g ? idata1 : idata0);
          wq.push_back('{cyc + 1, 1'(g), g ? idata1 : idata0});
        end else begin
          rq.push_back('{cyc + 1, 1'(g), 8'h00});
          pq.push_back('{cyc + 2, 1'(g), ms.pop_back()});
        end
      end
    end
  end

  task automatic step(input bit r, input bit v0, input bit o0, input logic [7:0] d0,
                      input bit v1, input bit o1, input logic [7:0] d1);
    @(posedge iclk);
    #1;
    ireset = r; ivalid0 = v0; iop0 = o0; idata0 = d0; ivalid1 = v1; iop1 = o1; idata1 = d1;
  endtask

  initial begin
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 8'hA5, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 8'h3C, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (10) step(0, 1, 0, 8'h11, 1, 0, 8'h22);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0, 8'h77);
    repeat (4) step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 0, 8'(8'hC0 + i));
      step(0, 0, 0, 0, 0, 0, 0);
    end
    repeat (4) step(0, 1, 0, 8'hEE, 0, 0, 0);
    step(0, 1, 0, 8'hEE, 1, 1, 0);
    repeat (4) step(0, 1, 0, 8'hEE, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 8'h5A, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 8'h01, 1, 0, 8'h02);
    for (int i = 0; i < 800; i++)
      step($urandom_range(59) == 0, 1'($urandom), 1'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom), 8'($urandom));
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
